// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants for the MIPS pipeline control blocks
//
// Purpose: FSM state encodings, default halt opcode and instruction field
// bounds shared by pipeline_run_ctrl and hazard_detect.
// Ports: none (package).
package mips_pkg;

  // Run controller states (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_PAUSE  = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

  // Instruction field bounds
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
//
// Purpose: flags a stall when the load in ID/EX writes a register that the
// instruction in IF/ID reads. Register 0 never creates a hazard.
// Ports:
//   i_mem_read_idex  ID/EX holds a load
//   i_rt_idex        ID/EX load destination
//   i_rs, i_rt       IF/ID source fields
//   o_stall          load-use hazard present
module hazard_detect
  import mips_pkg::*;
(
  input  logic       i_mem_read_idex,
  input  logic [4:0] i_rt_idex,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  output logic       o_stall
);

  logic w_dest_nonzero;
  logic w_src_match;

  assign w_dest_nonzero = (i_rt_idex != 5'd0);
  assign w_src_match    = (i_rt_idex == i_rs) || (i_rt_idex == i_rt);
  assign o_stall        = i_mem_read_idex && w_dest_nonzero && w_src_match;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// rtl/pipeline_run_ctrl.sv - run/step/halt and hazard controller for the 5-stage pipeline
//
// Purpose: sequences IDLE/RUN/STEP/PAUSE/DRAIN/HALTED and produces the PC,
// IF/ID and back-end enables plus flush strobes; counts run and stall cycles.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   start, step         run / single-cycle pulses
//   halt_req            level request to pause
//   instruction, rs, rt IF/ID contents
//   MemRead_IDEX, rt_IDEX, Branch_IDEX, Branch_EXMEM, PCSrc_MEMIF  pipeline status
//   pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pipe_en  stage controls
//   state, halted       FSM status
//   cycle_count         cycles with pipe_en=1 (saturating)
//   stall_count         load-use stall cycles (saturating)
module pipeline_run_ctrl
  import mips_pkg::*;
#(
  parameter int         CNT_WIDTH    = 32,
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [5:0] HALT_OPCODE  = HALT_OPCODE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic [31:0]          instruction,
  input  logic [4:0]           rs,
  input  logic [4:0]           rt,
  input  logic                 MemRead_IDEX,
  input  logic [4:0]           rt_IDEX,
  input  logic                 Branch_IDEX,
  input  logic                 Branch_EXMEM,
  input  logic                 PCSrc_MEMIF,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 pipe_en,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int              DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  logic [2:0]           r_state;
  logic [DW-1:0]        r_drain_cnt;
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic [CNT_WIDTH-1:0] r_stall_count;

  logic [2:0] w_next_state;
  logic       w_active;
  logic       w_load_use;
  logic       w_halt_op;
  logic       w_shadow;
  logic       w_count_stall;
  logic       w_enter_drain;
  logic       w_unused_bits;

  hazard_detect u_hazard_detect (
    .i_mem_read_idex (MemRead_IDEX),
    .i_rt_idex       (rt_IDEX),
    .i_rs            (rs),
    .i_rt            (rt),
    .o_stall         (w_load_use)
  );

  assign w_unused_bits = ^instruction[OPC_LO-1:0];

  assign w_active  = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_halt_op = (instruction[OPC_HI:OPC_LO] == HALT_OPCODE);
  assign w_shadow  = Branch_IDEX || Branch_EXMEM;

  // A taken branch outranks everything; a load-use stall outranks halt detection.
  assign w_count_stall = w_active && !PCSrc_MEMIF && w_load_use;
  assign w_enter_drain = w_active && !PCSrc_MEMIF && !w_load_use && w_halt_op && !w_shadow;

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_en     = 1'b0;
    if (w_active) begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      pipe_en = 1'b1;
      if (PCSrc_MEMIF) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (w_load_use || (w_halt_op && w_shadow)) begin
        // Halt in a branch shadow waits like a load-use bubble until the branch resolves.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (w_halt_op) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
      end
    end else if (r_state == ST_DRAIN) begin
      pipe_en = 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_PAUSE: begin
        if (start)     w_next_state = ST_RUN;
        else if (step) w_next_state = ST_STEP;
      end
      ST_RUN: begin
        if (w_enter_drain) w_next_state = ST_DRAIN;
        else if (halt_req) w_next_state = ST_PAUSE;
      end
      ST_STEP: begin
        w_next_state = w_enter_drain ? ST_DRAIN : ST_PAUSE;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) w_next_state = ST_HALTED;
      end
      ST_HALTED: w_next_state = ST_HALTED;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_drain_cnt   <= '0;
      r_cycle_count <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_enter_drain) begin
        r_drain_cnt <= DRAIN_LOAD;
      end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
        r_drain_cnt <= r_drain_cnt - 1'b1;
      end
      if (pipe_en && (r_cycle_count != {CNT_WIDTH{1'b1}})) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end
      if (w_count_stall && (r_stall_count != {CNT_WIDTH{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign state       = r_state;
  assign halted      = (r_state == ST_HALTED);
  assign cycle_count = r_cycle_count;
  assign stall_count = r_stall_count;

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
- Run/hazard controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates per-stage enable and flush strobes, sequences run/step/pause/halt, detects load-use hazards and branch-shadow flushes.
- Sits beside the pipeline top; its outputs gate the PC register and the IF/ID, ID/EX and EX/MEM latches.

Parameters:
- CNT_WIDTH, 32, width of cycle_count and stall_count
- DRAIN_CYCLES, 4, cycles the back end runs after halt detection, to retire older instructions
- HALT_OPCODE, 6'b111111, opcode field instruction[31:26] that marks a halt instruction

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse: enter continuous run
- step  in  1  one-cycle pulse: advance pipeline exactly one cycle
- halt_req  in  1  level: pause at the next cycle boundary
- instruction  in  32  current IF/ID instruction
- rs  in  5  IF/ID rs field
- rt  in  5  IF/ID rt field
- MemRead_IDEX  in  1  ID/EX holds a load
- rt_IDEX  in  5  ID/EX destination rt
- Branch_IDEX  in  1  branch in ID/EX
- Branch_EXMEM  in  1  branch in EX/MEM
- PCSrc_MEMIF  in  1  branch taken, resolved in MEM
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID latch enable
- ifid_flush  out  1  zero IF/ID contents
- idex_flush  out  1  insert bubble into ID/EX (control bits zero)
- exmem_flush  out  1  zero EX/MEM control bits
- pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB latches
- state  out  3  current FSM state encoding
- halted  out  1  high in HALTED
- cycle_count  out  CNT_WIDTH  cycles with pipe_en=1
- stall_count  out  CNT_WIDTH  load-use stall cycles

Behaviour:
- States: IDLE=0, RUN=1, STEP=2, PAUSE=3, DRAIN=4, HALTED=5. Reset (reset=0 at a clk edge) forces IDLE, zeroes both counters and the drain counter. Reset mid-DRAIN aborts the drain.
- Strobes are combinational from registered state plus current inputs. Counters and state are registered.
- In IDLE, PAUSE and HALTED all enables and flushes are 0 and halted=(state==HALTED).
- IDLE/PAUSE: start goes to RUN; else step goes to STEP. If start and step are both high, start wins.
- STEP lasts exactly one cycle with RUN-style strobes, then goes to PAUSE. A halt opcode seen during STEP goes to DRAIN instead.
- RUN: halt_req=1 goes to PAUSE at the next edge. The current cycle still executes.
- Base RUN/STEP strobes: pc_en=ifid_en=pipe_en=1 and flushes=0. Overrides below apply in this priority order.
  - 1. Branch taken (PCSrc_MEMIF=1): ifid_flush=idex_flush=exmem_flush=1, pc_en=1 (loads the branch target). This suppresses any load-use stall and any halt detection in the same cycle.
  - 2. Load-use hazard (MemRead_IDEX=1, rt_IDEX!=0, and rt_IDEX==rs or rt_IDEX==rt): pc_en=ifid_en=0, idex_flush=1, pipe_en=1. stall_count increments.
  - 3. Halt opcode in IF/ID (instruction[31:26]==HALT_OPCODE):
    - If Branch_IDEX or Branch_EXMEM is set, the halt is in a branch shadow: stall like a load-use hazard, but do not increment stall_count.
    - Otherwise: pc_en=ifid_en=0, ifid_flush=1; go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
- DRAIN: pc_en=ifid_en=0, pipe_en=1, flushes=0. The counter decrements each cycle; at 0 go to HALTED. start, step and halt_req are ignored.
- HALTED is sticky; only reset exits it.
- cycle_count increments on every cycle with pipe_en=1 and saturates at all-ones. stall_count also saturates.
- halt_req has no effect in IDLE, PAUSE, DRAIN or HALTED.

Decomposition:
- Shared package mips_pkg holds:
  - the state encoding constants
  - HALT_OPCODE default
  - opcode field bounds 31:26, rs 25:21, rt 20:16
- Natural sub-module: hazard_detect, the combinational load-use compare (rs, rt, rt_IDEX, MemRead_IDEX → stall). It is reusable by a future forwarding unit.

Test Plan:
- Reset held low 2 cycles, then high with no start → state=0, all enables 0, cycle_count=0.
- start pulse, 10 cycles of ADD instructions → state=1, pc_en=pipe_en=1 throughout, cycle_count=10.
- Load-use hazard: MemRead_IDEX=1, rt_IDEX=5, rs=5 → pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle, stall_count=1. Repeat with rt_IDEX=0 → no stall.
- PCSrc_MEMIF=1 in the same cycle as a load-use match and a halt opcode → all three flushes=1, pc_en=1, stall_count unchanged, state stays RUN.
- Halt opcode 0xFC000000 with Branch_EXMEM=0 → DRAIN for exactly 4 cycles with pipe_en=1, then state=5, halted=1. A start pulse afterwards leaves it HALTED.
- From PAUSE, step pulse → exactly one cycle with pipe_en=1, then state=3, cycle_count +1. Then pull reset low mid-DRAIN → IDLE, counters 0.
